i2c_bus_monitor: RTL

//  Protocol sequencer that sits after the per-line SCL/SDA debounce filters.

---
 rtl/i2c_bus_monitor.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_bus_monitor.sv
// I2C bus protocol monitor: decodes START/rSTART/STOP from filtered SCL/SDA,
// tracks bus busy/free, deserialises bytes plus ACK, and flags SCL-low timeouts.
module i2c_bus_monitor #(
  parameter int unsigned CLK_FREQ_MHZ    = 100,
  // Defaults derived from the clock: tBUF = 1.3 us, SCL-low timeout = 25 ms
  parameter int unsigned BUS_FREE_CYCLES = (CLK_FREQ_MHZ * 13) / 10,
  parameter int unsigned TIMEOUT_CYCLES  = CLK_FREQ_MHZ * 25_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_f,
  input  logic       sda_f,
  output logic       start_det,
  output logic       rstart_det,
  output logic       stop_det,
  output logic       bus_busy,
  output logic       bus_free,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       addr_phase,
  output logic       ack_valid,
  output logic       ack_bit,
  output logic [3:0] bit_cnt,
  output logic       timeout
);

  localparam int unsigned BF_W = $clog2(BUS_FREE_CYCLES + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BF_W-1:0] BF_MAX  = BF_W'(BUS_FREE_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_ACK
  } state_e;

  state_e          state_q, state_d;
  logic            scl_q, sda_q;
  logic            busy_q, busy_d;
  logic            free_q, free_d;
  logic [BF_W-1:0] bf_cnt_q, bf_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [6:0]      shreg_q, shreg_d;
  logic [7:0]      byte_data_q, byte_data_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            addr_q, addr_d;
  logic            ack_bit_q, ack_bit_d;
  logic            start_q, start_d;
  logic            rstart_q, rstart_d;
  logic            stop_q, stop_d;
  logic            bv_q, bv_d;
  logic            av_q, av_d;
  logic            to_q, to_d;

  logic start_c, stop_c, rise_c, to_fire;

  assign start_c = scl_q & scl_f &  sda_q & ~sda_f;
  assign stop_c  = scl_q & scl_f & ~sda_q &  sda_f;
  assign rise_c  = ~scl_q & scl_f;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    shreg_d     = shreg_q;
    byte_data_d = byte_data_q;
    bit_cnt_d   = bit_cnt_q;
    addr_d      = addr_q;
    ack_bit_d   = ack_bit_q;
    start_d     = 1'b0;
    rstart_d    = 1'b0;
    stop_d      = 1'b0;
    bv_d        = 1'b0;
    av_d        = 1'b0;
    to_d        = 1'b0;
    to_fire     = 1'b0;
    to_cnt_d    = '0;
    bf_cnt_d    = '0;

    if (busy_q && !scl_f) begin
      if (to_cnt_q == TO_LAST) begin
        to_fire = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end

    if (!busy_q && scl_f && sda_f) begin
      bf_cnt_d = (bf_cnt_q == BF_MAX) ? bf_cnt_q : bf_cnt_q + BF_W'(1);
    end
    free_d = (bf_cnt_d == BF_MAX);

    // Line conditions outrank the bit path; a STOP can never coincide with a
    // timeout because it needs SCL high, so the ordering here is sufficient.
    if (start_c) begin
      if (busy_q) rstart_d = 1'b1;
      else        start_d  = 1'b1;
      busy_d    = 1'b1;
      shreg_d   = '0;
      bit_cnt_d = '0;
      addr_d    = 1'b1;
      state_d   = S_DATA;
    end else if (stop_c) begin
      stop_d    = 1'b1;
      busy_d    = 1'b0;
      shreg_d   = '0;
      bit_cnt_d = '0;
      addr_d    = 1'b0;
      state_d   = S_IDLE;
    end else if (to_fire) begin
      to_d      = 1'b1;
      busy_d    = 1'b0;
      to_cnt_d  = '0;
      bit_cnt_d = '0;
      addr_d    = 1'b0;
      state_d   = S_IDLE;
    end else if (rise_c) begin
      unique case (state_q)
        S_DATA: begin
          if (bit_cnt_q == 4'd7) begin
            byte_data_d = {shreg_q, sda_f};
            bv_d        = 1'b1;
            bit_cnt_d   = 4'd8;
            state_d     = S_ACK;
          end else begin
            shreg_d   = {shreg_q[5:0], sda_f};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_ACK: begin
          ack_bit_d = sda_f;
          av_d      = 1'b1;
          bit_cnt_d = '0;
          addr_d    = 1'b0;
          shreg_d   = '0;
          state_d   = S_DATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      busy_q      <= 1'b0;
      free_q      <= 1'b0;
      bf_cnt_q    <= '0;
      to_cnt_q    <= '0;
      shreg_q     <= '0;
      byte_data_q <= '0;
      bit_cnt_q   <= '0;
      addr_q      <= 1'b0;
      ack_bit_q   <= 1'b1;
      start_q     <= 1'b0;
      rstart_q    <= 1'b0;
      stop_q      <= 1'b0;
      bv_q        <= 1'b0;
      av_q        <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      scl_q       <= scl_f;
      sda_q       <= sda_f;
      busy_q      <= busy_d;
      free_q      <= free_d;
      bf_cnt_q    <= bf_cnt_d;
      to_cnt_q    <= to_cnt_d;
      shreg_q     <= shreg_d;
      byte_data_q <= byte_data_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_q      <= addr_d;
      ack_bit_q   <= ack_bit_d;
      start_q     <= start_d;
      rstart_q    <= rstart_d;
      stop_q      <= stop_d;
      bv_q        <= bv_d;
      av_q        <= av_d;
      to_q        <= to_d;
    end
  end

  assign start_det  = start_q;
  assign rstart_det = rstart_q;
  assign stop_det   = stop_q;
  assign bus_busy   = busy_q;
  assign bus_free   = free_q;
  assign byte_valid = bv_q;
  assign byte_data  = byte_data_q;
  assign addr_phase = addr_q;
  assign ack_valid  = av_q;
  assign ack_bit    = ack_bit_q;
  assign bit_cnt    = bit_cnt_q;
  assign timeout    = to_q;

endmodule
